lsu: RTL and testbench

Load/store unit forming the memory stage directly downstream of the ALU. It takes the ALU result as an effective address, or as a pass-through result for non-memory ops. It drives a single-outstanding request/acknowledge data-memory bus with byte strobes, and hands aligned, sign/zero-extended load data to writeback. Misaligned accesses are detected here and reported without touching the bus.

---
 rtl/lsu_pkg.sv | 64 ++++++
 rtl/lsu_align.sv | 53 +++++
 rtl/lsu.sv | 228 ++++++++++++++++++++++
 tb/tb_lsu.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: bus op codes, RV32I width codes,
// FSM states and the access-size classification used by both RTL files.
package lsu_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] MEM_NONE  = 2'd0;
    localparam logic [1:0] MEM_LOAD  = 2'd1;
    localparam logic [1:0] MEM_STORE = 2'd2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_e;

    // Unknown width codes fall back to a full word.
    function automatic mem_size_e access_size(input logic is_store, input logic [2:0] f3);
        mem_size_e sz;
        sz = SZ_WORD;
        if (is_store) begin
            case (f3)
                F3_SB:   sz = SZ_BYTE;
                F3_SH:   sz = SZ_HALF;
                F3_SW:   sz = SZ_WORD;
                default: sz = SZ_WORD;
            endcase
        end else begin
            case (f3)
                F3_LB, F3_LBU: sz = SZ_BYTE;
                F3_LH, F3_LHU: sz = SZ_HALF;
                F3_LW:         sz = SZ_WORD;
                default:       sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

    function automatic logic is_misaligned(input mem_size_e sz, input logic [1:0] lane);
        logic mis;
        case (sz)
            SZ_HALF: mis = lane[0];
            SZ_WORD: mis = (lane != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store replication/strobes and load
// extract with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = lsu_pkg::XLEN
) (
    input  mem_size_e        i_st_size,
    input  logic [1:0]       i_st_lane,
    input  logic [XLEN-1:0]  i_st_data,
    output logic [XLEN-1:0]  o_st_wdata,
    output logic [3:0]       o_st_wstrb,
    input  mem_size_e        i_ld_size,
    input  logic             i_ld_unsigned,
    input  logic [1:0]       i_ld_lane,
    input  logic [XLEN-1:0]  i_ld_rdata,
    output logic [XLEN-1:0]  o_ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        o_st_wdata = i_st_data;
        o_st_wstrb = 4'b1111;
        case (i_st_size)
            SZ_BYTE: begin
                o_st_wdata = {4{i_st_data[7:0]}};
                o_st_wstrb = 4'b0001 << i_st_lane;
            end
            SZ_HALF: begin
                o_st_wdata = {2{i_st_data[15:0]}};
                o_st_wstrb = 4'b0011 << i_st_lane;
            end
            default: begin
                o_st_wdata = i_st_data;
                o_st_wstrb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        ld_byte   = i_ld_rdata[{i_ld_lane, 3'b000} +: 8];
        ld_half   = i_ld_lane[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
        o_ld_data = i_ld_rdata;
        case (i_ld_size)
            SZ_BYTE: o_ld_data = {{(XLEN-8){~i_ld_unsigned & ld_byte[7]}}, ld_byte};
            SZ_HALF: o_ld_data = {{(XLEN-16){~i_ld_unsigned & ld_half[15]}}, ld_half};
            default: o_ld_data = i_ld_rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Memory stage: single-outstanding req/ack data bus, misalignment trap,
// pass-through of ALU results, one-cycle writeback pulse. All outputs registered.
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN = lsu_pkg::XLEN
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_mem_op,
    input  logic [2:0]       i_funct3,
    input  logic [XLEN-1:0]  i_addr,
    input  logic [XLEN-1:0]  i_store_data,
    input  logic [4:0]       i_rd,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic [XLEN-1:0]  o_mem_addr,
    output logic [XLEN-1:0]  o_mem_wdata,
    output logic [3:0]       o_mem_wstrb,
    input  logic             i_mem_ack,
    input  logic [XLEN-1:0]  i_mem_rdata,
    output logic             o_wb_valid,
    output logic             o_wb_we,
    output logic [4:0]       o_wb_rd,
    output logic [XLEN-1:0]  o_wb_data,
    output logic             o_exc,
    output logic             o_exc_store,
    output logic [XLEN-1:0]  o_badaddr
);

    lsu_state_e      state_q, state_d;
    logic            ready_q, ready_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]      mem_wstrb_q, mem_wstrb_d;
    logic            wb_valid_q, wb_valid_d;
    logic            wb_we_q, wb_we_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            exc_q, exc_d;
    logic            exc_store_q, exc_store_d;
    logic [XLEN-1:0] badaddr_q, badaddr_d;

    // Load context kept across the bus phase.
    logic            is_load_q, is_load_d;
    logic [4:0]      rd_q, rd_d;
    logic [1:0]      lane_q, lane_d;
    mem_size_e       ld_size_q, ld_size_d;
    logic            ld_unsigned_q, ld_unsigned_d;

    logic            in_is_mem, in_is_store;
    mem_size_e       in_size;
    logic [XLEN-1:0] st_wdata, ld_data;
    logic [3:0]      st_wstrb;

    always_comb begin
        case (i_mem_op)
            MEM_NONE:  in_is_mem = 1'b0;
            MEM_LOAD:  in_is_mem = 1'b1;
            MEM_STORE: in_is_mem = 1'b1;
            default:   in_is_mem = 1'b0;
        endcase
        in_is_store = (i_mem_op == MEM_STORE);
        in_size     = access_size(in_is_store, i_funct3);
    end

    lsu_align #(.XLEN(XLEN)) u_align (
        .i_st_size     (in_size),
        .i_st_lane     (i_addr[1:0]),
        .i_st_data     (i_store_data),
        .o_st_wdata    (st_wdata),
        .o_st_wstrb    (st_wstrb),
        .i_ld_size     (ld_size_q),
        .i_ld_unsigned (ld_unsigned_q),
        .i_ld_lane     (lane_q),
        .i_ld_rdata    (i_mem_rdata),
        .o_ld_data     (ld_data)
    );

    always_comb begin
        state_d       = state_q;
        ready_d       = ready_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_wstrb_d   = mem_wstrb_q;
        wb_valid_d    = wb_valid_q;
        wb_we_d       = wb_we_q;
        wb_rd_d       = wb_rd_q;
        wb_data_d     = wb_data_q;
        exc_d         = exc_q;
        exc_store_d   = exc_store_q;
        badaddr_d     = badaddr_q;
        is_load_d     = is_load_q;
        rd_d          = rd_q;
        lane_d        = lane_q;
        ld_size_d     = ld_size_q;
        ld_unsigned_d = ld_unsigned_q;

        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    ready_d       = 1'b0;
                    is_load_d     = in_is_mem & ~in_is_store;
                    rd_d          = i_rd;
                    lane_d        = i_addr[1:0];
                    ld_size_d     = in_size;
                    ld_unsigned_d = i_funct3[2];
                    wb_rd_d       = i_rd;
                    if (!in_is_mem) begin
                        state_d    = ST_RESP;
                        wb_valid_d = 1'b1;
                        wb_we_d    = (i_rd != 5'd0);
                        wb_data_d  = i_addr;
                    end else if (is_misaligned(in_size, i_addr[1:0])) begin
                        state_d     = ST_RESP;
                        wb_valid_d  = 1'b1;
                        wb_we_d     = 1'b0;
                        wb_data_d   = '0;
                        exc_d       = 1'b1;
                        exc_store_d = in_is_store;
                        badaddr_d   = i_addr;
                    end else begin
                        state_d     = ST_BUS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = in_is_store;
                        mem_addr_d  = {i_addr[XLEN-1:2], 2'b00};
                        mem_wdata_d = in_is_store ? st_wdata : '0;
                        mem_wstrb_d = in_is_store ? st_wstrb : 4'b0000;
                    end
                end
            end
            ST_BUS: begin
                if (i_mem_ack) begin
                    state_d     = ST_RESP;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    mem_wstrb_d = 4'b0000;
                    wb_valid_d  = 1'b1;
                    wb_rd_d     = rd_q;
                    wb_we_d     = is_load_q && (rd_q != 5'd0);
                    wb_data_d   = is_load_q ? ld_data : '0;
                end
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                ready_d     = 1'b1;
                wb_valid_d  = 1'b0;
                wb_we_d     = 1'b0;
                wb_rd_d     = 5'd0;
                wb_data_d   = '0;
                exc_d       = 1'b0;
                exc_store_d = 1'b0;
                badaddr_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            ready_q       <= 1'b1;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_wstrb_q   <= 4'b0000;
            wb_valid_q    <= 1'b0;
            wb_we_q       <= 1'b0;
            wb_rd_q       <= 5'd0;
            wb_data_q     <= '0;
            exc_q         <= 1'b0;
            exc_store_q   <= 1'b0;
            badaddr_q     <= '0;
            is_load_q     <= 1'b0;
            rd_q          <= 5'd0;
            lane_q        <= 2'b00;
            ld_size_q     <= SZ_WORD;
            ld_unsigned_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ready_q       <= ready_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_wstrb_q   <= mem_wstrb_d;
            wb_valid_q    <= wb_valid_d;
            wb_we_q       <= wb_we_d;
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
            exc_q         <= exc_d;
            exc_store_q   <= exc_store_d;
            badaddr_q     <= badaddr_d;
            is_load_q     <= is_load_d;
            rd_q          <= rd_d;
            lane_q        <= lane_d;
            ld_size_q     <= ld_size_d;
            ld_unsigned_q <= ld_unsigned_d;
        end
    end

    assign o_ready     = ready_q;
    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_wstrb = mem_wstrb_q;
    assign o_wb_valid  = wb_valid_q;
    assign o_wb_we     = wb_we_q;
    assign o_wb_rd     = wb_rd_q;
    assign o_wb_data   = wb_data_q;
    assign o_exc       = exc_q;
    assign o_exc_store = exc_store_q;
    assign o_badaddr   = badaddr_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus randomized ops checked
// against an arithmetic reference model of the memory stage.
module tb_lsu;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [1:0]  i_mem_op = 2'd0;
    logic [2:0]  i_funct3 = 3'd0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_store_data = '0;
    logic [4:0]  i_rd = 5'd0;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wstrb;
    logic        i_mem_ack = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        o_wb_valid;
    logic        o_wb_we;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;
    logic        o_exc;
    logic        o_exc_store;
    logic [31:0] o_badaddr;

    int checks = 0;
    int errors = 0;

    lsu #(.XLEN(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_mem_op(i_mem_op), .i_funct3(i_funct3), .i_addr(i_addr),
        .i_store_data(i_store_data), .i_rd(i_rd),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
        .o_wb_valid(o_wb_valid), .o_wb_we(o_wb_we), .o_wb_rd(o_wb_rd),
        .o_wb_data(o_wb_data), .o_exc(o_exc), .o_exc_store(o_exc_store),
        .o_badaddr(o_badaddr)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: access size in bytes from op and funct3.
    function automatic int ref_size(input logic [1:0] op, input logic [2:0] f3);
        if (op == 2'd2) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] rdata);
        int sz;
        logic [31:0] mask, v;
        sz = ref_size(2'd1, f3);
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
        v = (rdata >> (8 * addr[1:0])) & mask;
        if ((f3 == 3'd0 || f3 == 3'd1) && sz < 4 && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        int sz;
        sz = ref_size(2'd2, f3);
        if (sz == 1) return {24'd0, d[7:0]} * 32'h0101_0101;
        if (sz == 2) return {16'd0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [3:0] ref_wstrb(input logic [2:0] f3, input logic [31:0] addr);
        int sz, m;
        sz = ref_size(2'd2, f3);
        m = ((1 << sz) - 1) << addr[1:0];
        return m[3:0];
    endfunction

    task automatic run_op(input string name, input logic [1:0] op, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd,
                          input int unsigned waits, input logic [31:0] rdata);
        logic is_mem, is_store, mis, exp_we;
        int sz;
        is_mem   = (op == 2'd1) || (op == 2'd2);
        is_store = (op == 2'd2);
        sz       = ref_size(op, f3);
        mis      = is_mem && ((addr % sz) != 0);

        @(negedge i_clk);
        checks++;
        if (o_ready !== 1'b1) begin
            errors++; $display("FAIL %s ready_before: got %b expected 1", name, o_ready);
        end
        i_valid = 1'b1; i_mem_op = op; i_funct3 = f3; i_addr = addr;
        i_store_data = sdata; i_rd = rd;
        @(negedge i_clk);
        i_valid = 1'b0; i_addr = $urandom; i_store_data = $urandom;

        if (is_mem && !mis) begin
            checks++;
            if (o_mem_req !== 1'b1 || o_mem_we !== is_store || o_mem_addr !== {addr[31:2], 2'b00}
                || o_wb_valid !== 1'b0 || o_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s bus_req: got req=%b we=%b addr=%h wbv=%b rdy=%b expected req=1 we=%b addr=%h wbv=0 rdy=0",
                         name, o_mem_req, o_mem_we, o_mem_addr, o_wb_valid, o_ready, is_store, {addr[31:2], 2'b00});
            end
            checks++;
            if (is_store ? (o_mem_wdata !== ref_wdata(f3, sdata) || o_mem_wstrb !== ref_wstrb(f3, addr))
                         : (o_mem_wstrb !== 4'b0000)) begin
                errors++;
                $display("FAIL %s bus_data: got wdata=%h wstrb=%b expected wdata=%h wstrb=%b", name,
                         o_mem_wdata, o_mem_wstrb, is_store ? ref_wdata(f3, sdata) : o_mem_wdata,
                         is_store ? ref_wstrb(f3, addr) : 4'b0000);
            end
            for (int unsigned w = 0; w < waits; w++) begin
                @(negedge i_clk);
                checks++;
                if (o_mem_req !== 1'b1 || o_mem_addr !== {addr[31:2], 2'b00} || o_wb_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s bus_hold: got req=%b addr=%h wbv=%b expected req=1 addr=%h wbv=0",
                             name, o_mem_req, o_mem_addr, o_wb_valid, {addr[31:2], 2'b00});
                end
            end
            i_mem_ack = 1'b1; i_mem_rdata = rdata;
            @(negedge i_clk);
            i_mem_ack = 1'b0; i_mem_rdata = $urandom;
            exp_we = !is_store && (rd != 5'd0);
            checks++;
            if (o_wb_valid !== 1'b1 || o_mem_req !== 1'b0 || o_wb_we !== exp_we || o_exc !== 1'b0) begin
                errors++;
                $display("FAIL %s bus_done: got wbv=%b req=%b we=%b exc=%b expected wbv=1 req=0 we=%b exc=0",
                         name, o_wb_valid, o_mem_req, o_wb_we, o_exc, exp_we);
            end
            if (!is_store) begin
                checks++;
                if (o_wb_data !== ref_load(f3, addr, rdata) || o_wb_rd !== rd) begin
                    errors++;
                    $display("FAIL %s load_data: got data=%h rd=%0d expected data=%h rd=%0d",
                             name, o_wb_data, o_wb_rd, ref_load(f3, addr, rdata), rd);
                end
            end
        end else begin
            exp_we = !is_mem && (rd != 5'd0);
            checks++;
            if (o_wb_valid !== 1'b1 || o_mem_req !== 1'b0 || o_exc !== mis || o_wb_we !== exp_we) begin
                errors++;
                $display("FAIL %s resp: got wbv=%b req=%b exc=%b we=%b expected wbv=1 req=0 exc=%b we=%b",
                         name, o_wb_valid, o_mem_req, o_exc, o_wb_we, mis, exp_we);
            end
            checks++;
            if (mis ? (o_exc_store !== is_store || o_badaddr !== addr)
                    : (o_wb_data !== addr || o_wb_rd !== rd)) begin
                errors++;
                $display("FAIL %s resp_data: got exc_store=%b badaddr=%h data=%h rd=%0d for addr=%h rd=%0d store=%b",
                         name, o_exc_store, o_badaddr, o_wb_data, o_wb_rd, addr, rd, is_store);
            end
        end

        @(negedge i_clk);
        checks++;
        if (o_wb_valid !== 1'b0 || o_ready !== 1'b1 || o_mem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s after: got wbv=%b rdy=%b req=%b expected wbv=0 rdy=1 req=0",
                     name, o_wb_valid, o_ready, o_mem_req);
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        checks++;
        if (o_ready !== 1'b1 || o_mem_req !== 1'b0 || o_mem_we !== 1'b0 || o_mem_addr !== 32'd0 ||
            o_mem_wdata !== 32'd0 || o_mem_wstrb !== 4'd0 || o_wb_valid !== 1'b0 || o_wb_we !== 1'b0 ||
            o_wb_rd !== 5'd0 || o_wb_data !== 32'd0 || o_exc !== 1'b0 || o_exc_store !== 1'b0 ||
            o_badaddr !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b req=%b wbv=%b exc=%b addr=%h data=%h expected rdy=1 and all else 0",
                     o_ready, o_mem_req, o_wb_valid, o_exc, o_mem_addr, o_wb_data);
        end
        i_rst_n = 1'b1;
    endtask

    task automatic test_passthrough();
        run_op("pass_rd5", 2'd0, 3'd0, 32'h1234_5678, 32'h0, 5'd5, 0, 32'h0);
        run_op("pass_rd0", 2'd0, 3'd2, 32'hCAFE_F00D, 32'h0, 5'd0, 0, 32'h0);
        run_op("pass_op3", 2'd3, 3'd1, 32'h0000_0003, 32'h0, 5'd9, 0, 32'h0);
    endtask

    task automatic test_store();
        run_op("sb_1003", 2'd2, 3'd0, 32'h0000_1003, 32'h0000_00AB, 5'd7, 3, 32'h0);
        run_op("sh_1002", 2'd2, 3'd1, 32'h0000_1002, 32'h1234_BEEF, 5'd1, 1, 32'h0);
        run_op("sw_1004", 2'd2, 3'd2, 32'h0000_1004, 32'hDEAD_BEEF, 5'd2, 0, 32'h0);
        run_op("sx_f3_7", 2'd2, 3'd7, 32'h0000_1008, 32'h0BAD_CAFE, 5'd2, 0, 32'h0);
    endtask

    task automatic test_load();
        run_op("lb_2003",  2'd1, 3'd0, 32'h0000_2003, 32'h0, 5'd4, 2, 32'h80FF_7F00);
        run_op("lbu_2003", 2'd1, 3'd4, 32'h0000_2003, 32'h0, 5'd4, 0, 32'h80FF_7F00);
        run_op("lh_2002",  2'd1, 3'd1, 32'h0000_2002, 32'h0, 5'd4, 1, 32'h80FF_7F00);
        run_op("lhu_2000", 2'd1, 3'd5, 32'h0000_2000, 32'h0, 5'd4, 0, 32'h80FF_8F00);
        run_op("lb_2001",  2'd1, 3'd0, 32'h0000_2001, 32'h0, 5'd0, 0, 32'h80FF_7F00);
    endtask

    task automatic test_misaligned();
        run_op("mis_lw", 2'd1, 3'd2, 32'h0000_3002, 32'h0, 5'd3, 0, 32'h0);
        run_op("mis_sh", 2'd2, 3'd1, 32'h0000_3001, 32'h0, 5'd3, 0, 32'h0);
        run_op("mis_lhu", 2'd1, 3'd5, 32'h0000_3003, 32'h0, 5'd3, 0, 32'h0);
        run_op("mis_sw_f3x", 2'd2, 3'd6, 32'h0000_3001, 32'h0, 5'd3, 0, 32'h0);
    endtask

    task automatic test_reset_mid_bus();
        @(negedge i_clk);
        i_valid = 1'b1; i_mem_op = 2'd2; i_funct3 = 3'd2; i_addr = 32'h0000_4000;
        i_store_data = 32'h1111_2222; i_rd = 5'd1;
        @(negedge i_clk);
        i_valid = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_mem_req !== 1'b1) begin
            errors++; $display("FAIL rst_bus_req: got %b expected 1", o_mem_req);
        end
        i_rst_n = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_mem_ack = 1'b1; i_mem_rdata = 32'hFFFF_FFFF;
        @(negedge i_clk);
        i_mem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o_mem_req !== 1'b0 || o_wb_valid !== 1'b0 || o_ready !== 1'b1) begin
                errors++;
                $display("FAIL rst_bus_after: got req=%b wbv=%b rdy=%b expected req=0 wbv=0 rdy=1",
                         o_mem_req, o_wb_valid, o_ready);
            end
            @(negedge i_clk);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge i_clk);
        i_valid = 1'b1; i_mem_op = 2'd1; i_funct3 = 3'd2; i_addr = 32'h10;
        i_store_data = 32'h0; i_rd = 5'd3;
        @(negedge i_clk);
        checks++;
        if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h10 || o_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_req1: got req=%b addr=%h rdy=%b expected 1 00000010 0", o_mem_req, o_mem_addr, o_ready);
        end
        i_addr = 32'h14; i_rd = 5'd0;
        i_mem_ack = 1'b1; i_mem_rdata = 32'hAAAA_0001;
        @(negedge i_clk);
        i_mem_ack = 1'b0;
        checks++;
        if (o_wb_valid !== 1'b1 || o_wb_data !== 32'hAAAA_0001 || o_wb_we !== 1'b1 || o_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_wb1: got wbv=%b data=%h we=%b rdy=%b expected 1 aaaa0001 1 0", o_wb_valid, o_wb_data, o_wb_we, o_ready);
        end
        @(negedge i_clk);
        checks++;
        if (o_wb_valid !== 1'b0 || o_ready !== 1'b1 || o_mem_req !== 1'b0) begin
            errors++; $display("FAIL b2b_gap: got wbv=%b rdy=%b req=%b expected 0 1 0", o_wb_valid, o_ready, o_mem_req);
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        checks++;
        if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h14) begin
            errors++; $display("FAIL b2b_req2: got req=%b addr=%h expected 1 00000014", o_mem_req, o_mem_addr);
        end
        i_mem_ack = 1'b1; i_mem_rdata = 32'hBBBB_0002;
        @(negedge i_clk);
        i_mem_ack = 1'b0;
        checks++;
        if (o_wb_valid !== 1'b1 || o_wb_data !== 32'hBBBB_0002 || o_wb_we !== 1'b0) begin
            errors++; $display("FAIL b2b_wb2: got wbv=%b data=%h we=%b expected 1 bbbb0002 0", o_wb_valid, o_wb_data, o_wb_we);
        end
        @(negedge i_clk);
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [2:0]  f3;
        logic [31:0] addr, sdata, rdata;
        logic [4:0]  rd;
        for (int n = 0; n < 60; n++) begin
            op    = 2'($urandom_range(0, 3));
            f3    = 3'($urandom_range(0, 7));
            addr  = $urandom;
            sdata = $urandom;
            rdata = $urandom;
            rd    = 5'($urandom_range(0, 31));
            run_op("random", op, f3, addr, sdata, rd, $urandom_range(0, 3), rdata);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_store();
        test_load();
        test_misaligned();
        test_reset_mid_bus();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
